vga_stream_reader: RTL and testbench
====================================

// Module: vga_stream_reader
// PURPOSE
//  Consumer end of the Nios VGA pixel stream: pulls bytes from the vga_stream_out
//  PIO export with the vga_stream_read strobe and buffers them in a small FIFO.
//  Delivers one 6-bit NES palette index per pixel request to the VGA scan-out.
//  Frame alignment uses the start-of-frame marker bit in the stream.
// PARAMETERS
//  FIFO_DEPTH      16  pixel FIFO entries; power of two, >=4
//  READ_LATENCY    2   vga_clk cycles from strobe to next byte valid on stream_data; 1..7
//  UNDERFLOW_PIX   6'h0F  index output when a request hits an empty FIFO (NES black)
// PORTS
//  vga_clk        in   1  sole clock; all logic rising-edge
//  reset          in   1  asynchronous, active-high
//  stream_data    in   8  from vga_stream_out_export; [7]=SOF, [6]=rsvd, [5:0]=palette idx
//  stream_read    out  1  to vga_stream_read_export; 1-cycle pulse = byte consumed
//  frame_sync     in   1  1-cycle pulse at VGA vertical blank start; forces resync
//  pix_req        in   1  scan-out wants a pixel this cycle
//  pix_data       out  6  palette index, registered, valid cycle after pix_req
//  pix_valid      out  1  1 = pix_data from FIFO; 0 = underflow filler
//  underflow      out  1  sticky; set on any pix_req with FIFO empty in STREAM
//  fifo_level     out  log2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset: stream_read=0, pix_data=UNDERFLOW_PIX, pix_valid=0, underflow=0,
//   fifo_level=0, FSM=SYNC, FIFO pointers 0. Reset mid-fetch aborts; no strobe issued.
//  Fetch FSM:
//   SYNC   : sample stream_data; if [7]=0 pulse stream_read, go WAIT (discard byte);
//            if [7]=1 go FILL (SOF byte kept, not consumed yet).
//   FILL   : if FIFO not full: write stream_data[5:0], pulse stream_read, go WAIT.
//            If full: hold, no strobe.
//   WAIT   : count READ_LATENCY cycles with no strobe, then return to caller state
//            (SYNC if discarding, else FILL). Guarantees strobes >=READ_LATENCY+1 apart.
//   A byte with [7]=1 seen in FILL is written normally (mid-frame SOF = resync is
//   driven only by frame_sync, not by data).
//  frame_sync: synchronous flush -- FIFO pointers cleared, fifo_level=0, FSM->SYNC,
//   WAIT counter cleared; takes effect next edge; a strobe in the same cycle still
//   completes (pulse is not extended). underflow is NOT cleared by frame_sync.
//  Scan-out side (independent of FSM state except SYNC):
//   pix_req & FIFO non-empty -> pop; next cycle pix_data=head, pix_valid=1.
//   pix_req & FIFO empty     -> next cycle pix_data=UNDERFLOW_PIX, pix_valid=0;
//                               underflow set unless FSM in SYNC (blank/resync time).
//   No pix_req -> pix_data holds, pix_valid=0.
//  Simultaneous push and pop: both occur, level unchanged; push to full FIFO never
//   happens (FILL checks full); pop on a FIFO with one entry while pushing returns
//   the old head (no bypass).
//  Pointers wrap modulo FIFO_DEPTH; full = level==FIFO_DEPTH, empty = level==0.
//  underflow clears only on reset.
// TESTING
//  1 Reset, stream bytes 0x05,0x06 then 0x80|0x21,0x22.. -> two strobes discard 05,06;
//    first FIFO entry 0x21, pix_data sequence 21,22,.. with pix_valid=1.
//  2 READ_LATENCY=2, FIFO never full -> stream_read pulses exactly every 3 cycles,
//    single-cycle width.
//  3 pix_req held low until fifo_level=16 -> stream_read stays 0; one pix_req ->
//    exactly one further strobe after level drops to 15.
//  4 pix_req every cycle with producer slower than consumer -> empty hit gives
//    pix_data=0x0F, pix_valid=0, underflow=1 and stays 1 through frame_sync.
//  5 frame_sync pulse with level=9 -> level 0 next cycle, FSM discards until byte[7]=1,
//    no pix_valid until new SOF pixel popped.
//  6 Assert reset in WAIT mid-fill -> all outputs at reset values immediately (async),
//    first strobe after release only after SOF seen.

Source files
------------

// File: rtl/vga_stream_reader.sv
// vga_stream_reader: pulls palette bytes from the Nios VGA stream into a FIFO and
// hands one 6-bit index per scan-out request, aligning frames on the SOF marker.
module vga_stream_reader #(
    parameter int          FIFO_DEPTH    = 16,
    parameter int          READ_LATENCY  = 2,
    parameter logic [5:0]  UNDERFLOW_PIX = 6'h0F
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic [7:0]                    stream_data,
    output logic                          stream_read,
    input  logic                          frame_sync,
    input  logic                          pix_req,
    output logic [5:0]                    pix_data,
    output logic                          pix_valid,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SYNC, FILL, WAIT} state_t;

    state_t        state, state_nx, ret, ret_nx;
    logic [2:0]    cnt, cnt_nx;
    logic          rd_nx, push, pop, full, empty;
    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;

    assign full  = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign empty = fifo_level == '0;
    assign pop   = pix_req && !empty;

    // The strobe is registered, so the byte sampled at the deciding edge is the one consumed
    always_comb begin
        state_nx = state;
        ret_nx   = ret;
        cnt_nx   = cnt;
        rd_nx    = 1'b0;
        push     = 1'b0;
        if (frame_sync) begin
            state_nx = SYNC;
            cnt_nx   = '0;
        end else begin
            case (state)
                SYNC: begin
                    state_nx = stream_data[7] ? FILL : WAIT;
                    rd_nx    = !stream_data[7];
                    ret_nx   = SYNC;
                    cnt_nx   = '0;
                end
                FILL: begin
                    push     = !full;
                    rd_nx    = !full;
                    state_nx = full ? FILL : WAIT;
                    ret_nx   = FILL;
                    cnt_nx   = '0;
                end
                default: begin
                    state_nx = (cnt == 3'(READ_LATENCY - 1)) ? ret : WAIT;
                    cnt_nx   = (cnt == 3'(READ_LATENCY - 1)) ? 3'd0 : cnt + 3'd1;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (push) mem[wp] <= stream_data[5:0];
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state       <= SYNC;
            ret         <= SYNC;
            cnt         <= '0;
            stream_read <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            fifo_level  <= '0;
            pix_data    <= UNDERFLOW_PIX;
            pix_valid   <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_nx;
            ret         <= ret_nx;
            cnt         <= cnt_nx;
            stream_read <= rd_nx;
            if (frame_sync) begin
                wp         <= '0;
                rp         <= '0;
                fifo_level <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            end
            pix_valid <= pop;
            if (pix_req) pix_data <= empty ? UNDERFLOW_PIX : mem[rp];
            if (pix_req && empty && state != SYNC) underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_stream_reader.sv
// tb_vga_stream_reader: directed vectors against a byte-stream producer model.
module tb_vga_stream_reader;
    logic       vga_clk = 1'b0;
    logic       reset, frame_sync, pix_req, stream_read, pix_valid, underflow;
    logic [7:0] stream_data;
    logic [5:0] pix_data;
    logic [4:0] fifo_level;
    logic [7:0] src [256];
    logic [7:0] sp = 8'd0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic       req;
        logic       exp_valid;
        logic [5:0] exp_data;
    } vec_t;
    vec_t vecs [8];

    vga_stream_reader dut (
        .vga_clk(vga_clk), .reset(reset), .stream_data(stream_data),
        .stream_read(stream_read), .frame_sync(frame_sync), .pix_req(pix_req),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
        .fifo_level(fifo_level)
    );

    always #5 vga_clk = ~vga_clk;

    // Producer: a strobe seen at an edge advances to the next byte
    assign stream_data = src[sp];
    always @(posedge vga_clk) if (stream_read) sp <= sp + 8'd1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b1, 6'h21};
        vecs[1] = '{1'b1, 1'b1, 6'h22};
        vecs[2] = '{1'b0, 1'b0, 6'h22};
        vecs[3] = '{1'b1, 1'b1, 6'h23};
        vecs[4] = '{1'b1, 1'b1, 6'h24};
        vecs[5] = '{1'b1, 1'b1, 6'h25};
        vecs[6] = '{1'b1, 1'b1, 6'h26};
        vecs[7] = '{1'b1, 1'b1, 6'h27};
        src[0] = 8'h05;
        src[1] = 8'h06;
        src[2] = 8'hA1;
        for (int i = 3; i < 256; i++) src[i] = 8'((i + 31) % 64);
        reset = 1'b1;
        frame_sync = 1'b0;
        pix_req = 1'b0;
        #12;
        chk("rst_read", stream_read, 0);
        chk("rst_data", pix_data, 6'h0F);
        chk("rst_valid", pix_valid, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_level", fifo_level, 0);
        @(negedge vga_clk) reset = 1'b0;

        // discard 05,06 then fill from SOF; drain through the vector table
        for (int i = 0; i < 80 && fifo_level != 5'd6; i++) @(negedge vga_clk);
        chk("fill_level6", fifo_level, 6);
        for (int v = 0; v < 8; v++) begin
            pix_req = vecs[v].req;
            @(negedge vga_clk);
            chk($sformatf("vec%0d_valid", v), pix_valid, vecs[v].exp_valid);
            chk($sformatf("vec%0d_data", v), pix_data, vecs[v].exp_data);
            chk($sformatf("vec%0d_uf", v), underflow, 0);
        end
        pix_req = 1'b0;

        // strobe cadence: READ_LATENCY+1 cycles apart, single-cycle wide
        for (int i = 0; i < 10 && !stream_read; i++) @(negedge vga_clk);
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge vga_clk);
                n++;
            end while (!stream_read && n < 10);
            chk("strobe_gap", n, 3);
        end

        // full FIFO stops strobes; one pop allows exactly one more
        for (int i = 0; i < 120 && fifo_level != 5'd16; i++) @(negedge vga_clk);
        chk("full_level", fifo_level, 16);
        n = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge vga_clk);
            if (i >= 2 && stream_read) n++;
        end
        chk("full_no_strobe", n, 0);
        pix_req = 1'b1;
        @(negedge vga_clk) pix_req = 1'b0;
        chk("full_pop_valid", pix_valid, 1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge vga_clk);
            if (stream_read) n++;
        end
        chk("refill_strobes", n, 1);
        chk("refill_level", fifo_level, 16);

        // consumer outruns producer -> underflow filler and sticky flag
        chk("pre_uf", underflow, 0);
        pix_req = 1'b1;
        @(negedge vga_clk);
        chk("drain_valid", pix_valid, 1);
        for (int i = 0; i < 60 && pix_valid; i++) @(negedge vga_clk);
        chk("uf_valid", pix_valid, 0);
        chk("uf_data", pix_data, 6'h0F);
        chk("uf_flag", underflow, 1);
        pix_req = 1'b0;

        // frame_sync flush at level 9, resync on next SOF
        for (int i = 0; i < 100 && fifo_level != 5'd9; i++) @(negedge vga_clk);
        chk("pre_sync_level", fifo_level, 9);
        src[8'(sp + 0)] = 8'h11;
        src[8'(sp + 1)] = 8'h12;
        src[8'(sp + 2)] = 8'h13;
        src[8'(sp + 3)] = 8'hB0;
        src[8'(sp + 4)] = 8'h31;
        src[8'(sp + 5)] = 8'h32;
        frame_sync = 1'b1;
        @(negedge vga_clk) frame_sync = 1'b0;
        chk("sync_level", fifo_level, 0);
        chk("sync_uf_sticky", underflow, 1);
        pix_req = 1'b1;
        for (int i = 0; i < 80 && !pix_valid; i++) @(negedge vga_clk);
        chk("resync_valid", pix_valid, 1);
        chk("resync_first", pix_data, 6'h30);
        @(negedge vga_clk);
        for (int i = 0; i < 20 && !pix_valid; i++) @(negedge vga_clk);
        chk("resync_second", pix_data, 6'h31);
        pix_req = 1'b0;

        // async reset while a strobe is outstanding
        for (int i = 0; i < 10 && !stream_read; i++) @(negedge vga_clk);
        chk("pre_rst_strobe", stream_read, 1);
        #2 reset = 1'b1;
        src[sp] = 8'h85;
        src[8'(sp + 1)] = 8'h06;
        #1;
        chk("arst_read", stream_read, 0);
        chk("arst_data", pix_data, 6'h0F);
        chk("arst_valid", pix_valid, 0);
        chk("arst_uf", underflow, 0);
        chk("arst_level", fifo_level, 0);
        @(negedge vga_clk);
        @(negedge vga_clk) reset = 1'b0;
        for (int i = 0; i < 10 && !stream_read; i++) @(negedge vga_clk);
        chk("post_rst_strobe", stream_read, 1);
        chk("post_rst_level", fifo_level, 1);
        pix_req = 1'b1;
        @(negedge vga_clk) pix_req = 1'b0;
        chk("post_rst_valid", pix_valid, 1);
        chk("post_rst_data", pix_data, 6'h05);
        chk("post_rst_uf", underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
